// File: rtl/zm_adsr_env_pkg.sv
// Shared types and constants for the sample-rate ADSR envelope.
// State codes are fixed because stage_out exposes them to the bus side.
package zm_env_pkg;

    localparam int          ENV_STAGE_W = 3;
    localparam logic [15:0] LEVEL_MAX   = 16'hFFFF;

    typedef enum logic [ENV_STAGE_W-1:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/zm_adsr_env_if.sv
// Envelope control/status bundle: the word clock, the gate, four rate/level
// settings in, and the envelope level and stage out.
interface zm_adsr_env_if
    import zm_env_pkg::*;
#(
    parameter int LEVEL_W = 16
);

    logic                   lrck;
    logic                   gate;
    logic [LEVEL_W-1:0]     attack_rate;
    logic [LEVEL_W-1:0]     decay_rate;
    logic [LEVEL_W-1:0]     sustain_level;
    logic [LEVEL_W-1:0]     release_rate;
    logic [LEVEL_W-1:0]     level_out;
    logic [ENV_STAGE_W-1:0] stage_out;
    logic                   active_out;

    modport master (
        output lrck, gate, attack_rate, decay_rate, sustain_level, release_rate,
        input  level_out, stage_out, active_out
    );

    modport slave (
        input  lrck, gate, attack_rate, decay_rate, sustain_level, release_rate,
        output level_out, stage_out, active_out
    );

endinterface

// File: rtl/zm_adsr_env_tick_sync.sv
// Brings an asynchronous sample clock into the clk domain and emits a
// one-clk tick on each of its rising edges, SYNC_STAGES+1 clk after the rise.
module zm_tick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   tick_q;

    // The edge detector is registered so the tick is a clean flop output.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            tick_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/zm_adsr_env.sv
// Sample-rate ADSR envelope generator driving the VCA level.
// Build option: define ZM_ENV_EXP_RELEASE_EN for an exponential release.
module zm_adsr_env
    import zm_env_pkg::*;
#(
    parameter int LEVEL_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    zm_adsr_env_if.slave  env
);

    localparam logic [LEVEL_W-1:0] LvlMax = {LEVEL_W{1'b1}};
    localparam logic [LEVEL_W-1:0] LvlOne = {{(LEVEL_W-1){1'b0}}, 1'b1};

    logic                   tick;
    env_state_t             state_q, state_d, stageEff;
    logic [LEVEL_W-1:0]     level_q, level_d;
    logic                   gate_q;
    logic [ENV_STAGE_W-1:0] stage_q;
    logic                   active_q;
    logic                   gateRise, gateFall;
    logic [LEVEL_W:0]       attackSum, decayDiff, releaseDiff;
`ifdef ZM_ENV_EXP_RELEASE_EN
    logic [LEVEL_W-1:0]     releaseStep;
`endif

    zm_tick_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .async_in (env.lrck),
        .tick     (tick)
    );

    // Gate edges pick the stage first; the tick arithmetic then runs in that
    // stage, so an edge coinciding with a tick uses the new stage's math.
    always_comb begin
        gateRise  = env.gate & ~gate_q;
        gateFall  = ~env.gate & gate_q;
        attackSum = {1'b0, level_q} + {1'b0, env.attack_rate};
        decayDiff = {1'b0, level_q} - {1'b0, env.decay_rate};
`ifdef ZM_ENV_EXP_RELEASE_EN
        releaseStep = level_q >> env.release_rate[3:0];
        if (releaseStep == '0) begin
            releaseStep = LvlOne;
        end
        releaseDiff = {1'b0, level_q} - {1'b0, releaseStep};
`else
        releaseDiff = {1'b0, level_q} - {1'b0, env.release_rate};
`endif

        stageEff = state_q;
        if (gateRise) begin
            stageEff = ENV_ATTACK;
        end else if (gateFall && (state_q == ENV_ATTACK || state_q == ENV_DECAY ||
                                  state_q == ENV_SUSTAIN)) begin
            stageEff = ENV_RELEASE;
        end

        state_d = stageEff;
        level_d = level_q;
        if (tick) begin
            case (stageEff)
                ENV_IDLE: begin
                    level_d = '0;
                end
                ENV_ATTACK: begin
                    if (attackSum >= {1'b0, LvlMax}) begin
                        level_d = LvlMax;
                        state_d = ENV_DECAY;
                    end else begin
                        level_d = attackSum[LEVEL_W-1:0];
                    end
                end
                ENV_DECAY: begin
                    if (decayDiff[LEVEL_W] || decayDiff[LEVEL_W-1:0] <= env.sustain_level) begin
                        level_d = env.sustain_level;
                        state_d = ENV_SUSTAIN;
                    end else begin
                        level_d = decayDiff[LEVEL_W-1:0];
                    end
                end
                ENV_SUSTAIN: begin
                    level_d = env.sustain_level;
                end
                ENV_RELEASE: begin
                    if (releaseDiff[LEVEL_W] || releaseDiff[LEVEL_W-1:0] == '0) begin
                        level_d = '0;
                        state_d = ENV_IDLE;
                    end else begin
                        level_d = releaseDiff[LEVEL_W-1:0];
                    end
                end
                default: begin
                    level_d = '0;
                    state_d = ENV_IDLE;
                end
            endcase
        end

        // A corrupted state code always falls back to silence.
        if (state_q > ENV_RELEASE) begin
            state_d = ENV_IDLE;
            level_d = '0;
        end
    end

    // Stage and active flags are registered from state_d so they move with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ENV_IDLE;
            level_q  <= '0;
            gate_q   <= 1'b0;
            stage_q  <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            gate_q   <= env.gate;
            stage_q  <= state_d;
            active_q <= (state_d != ENV_IDLE);
        end
    end

    assign env.level_out  = level_q;
    assign env.stage_out  = stage_q;
    assign env.active_out = active_q;

endmodule

// File: tb/tb_zm_adsr_env.sv
// Directed bench for zm_adsr_env: vector table plus hand sequences for
// tick latency, full ADSR, retrigger and gate/tick coincidence.
module tb_zm_adsr_env;
    import zm_env_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   nCompared = 0;
    int   nMismatched = 0;

    zm_adsr_env_if #(.LEVEL_W(16)) envIf ();

    zm_adsr_env #(
        .LEVEL_W     (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .env   (envIf.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        tck;
        logic        gate;
        logic [15:0] atk;
        logic [15:0] dec;
        logic [15:0] sus;
        logic [15:0] rel;
        logic [15:0] expLevel;
        logic [2:0]  expStage;
    } vec_t;

    vec_t vecs[19];

    task automatic checkOutput(input string name, input logic [15:0] expLevel,
                               input logic [2:0] expStage);
        logic expActive;
        expActive = (expStage != 3'd0);
        nCompared += 3;
        if (envIf.level_out !== expLevel) begin
            nMismatched++;
            $display("[TB] FAIL %s level: got %h expected %h", name, envIf.level_out, expLevel);
        end
        if (envIf.stage_out !== expStage) begin
            nMismatched++;
            $display("[TB] FAIL %s stage: got %0d expected %0d", name, envIf.stage_out, expStage);
        end
        if (envIf.active_out !== expActive) begin
            nMismatched++;
            $display("[TB] FAIL %s active: got %b expected %b", name, envIf.active_out, expActive);
        end
    endtask

    task automatic applyStimulus(input logic g, input logic [15:0] atk, input logic [15:0] dec,
                                 input logic [15:0] sus, input logic [15:0] rel);
        envIf.gate          = g;
        envIf.attack_rate   = atk;
        envIf.decay_rate    = dec;
        envIf.sustain_level = sus;
        envIf.release_rate  = rel;
    endtask

    // One lrck period; optionally changes the gate in the clk where tick is high.
    task automatic doTick(input bit gateWithTick, input logic newGate);
        @(negedge clk) envIf.lrck = 1'b1;
        repeat (3) @(negedge clk);
        if (gateWithTick) envIf.gate = newGate;
        @(negedge clk);
        envIf.lrck = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic doReset();
        envIf.gate = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic goSustain(input logic [15:0] lvl);
        doReset();
        applyStimulus(1'b1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
        doTick(1'b0, 1'b0);
        checkOutput("goSustainAttack", LEVEL_MAX, 3'd2);
        applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, lvl, 16'h0000);
        doTick(1'b0, 1'b0);
        checkOutput("goSustain", lvl, 3'd3);
    endtask

    initial begin
        reset = 1'b1;
        envIf.lrck = 1'b0;
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        //               rst   tck   gate  atk       dec       sus       rel       level     stage
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h2000, 3'd1};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 16'hF000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 3'd2};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 16'hF000, 16'hFFFF, 16'h1234, 16'h0000, 16'h1234, 3'd3};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'hF000, 16'hFFFF, 16'h2000, 16'h0000, 16'h2000, 3'd3};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 16'hF000, 16'hFFFF, 16'h0005, 16'h0000, 16'h0005, 3'd3};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 3'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 3'd4};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 3'd1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 3'd2};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'h1000, 16'h0000, 16'hFFFF, 3'd2};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0100, 16'h1000, 16'h0000, 16'hFEFF, 3'd2};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0100, 16'hFF00, 16'h0000, 16'hFF00, 3'd3};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0100, 16'hFFFF, 16'h0000, 16'hFFFF, 3'd3};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0100, 16'hFFFF, 16'h0000, 16'hFFFF, 3'd4};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0};

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].gate, vecs[i].atk, vecs[i].dec, vecs[i].sus, vecs[i].rel);
            if (vecs[i].rst) begin
                reset = 1'b1;
                @(negedge clk);
                checkOutput($sformatf("vec%0d", i), vecs[i].expLevel, vecs[i].expStage);
                reset = 1'b0;
            end else begin
                if (vecs[i].tck) doTick(1'b0, 1'b0);
                else repeat (2) @(negedge clk);
                checkOutput($sformatf("vec%0d", i), vecs[i].expLevel, vecs[i].expStage);
            end
        end

        // Reset in the middle of an attack, then confirm nothing resumes.
        doReset();
        applyStimulus(1'b1, 16'h1000, 16'h0000, 16'h0000, 16'h0000);
        for (int i = 0; i < 4; i++) doTick(1'b0, 1'b0);
        checkOutput("preReset", 16'h4000, 3'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midAttackReset", 16'h0000, 3'd0);
        envIf.gate = 1'b0;
        reset = 1'b0;
        doTick(1'b0, 1'b0);
        checkOutput("noResume", 16'h0000, 3'd0);

        // Tick appears exactly on the third clk after each lrck rise.
        for (int p = 0; p < 2; p++) begin
            @(negedge clk) envIf.lrck = 1'b1;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                nCompared++;
                if (dut.u_tick.tick !== (k == 3)) begin
                    nMismatched++;
                    $display("[TB] FAIL tickLatency p%0d k%0d: got %b expected %b",
                             p, k, dut.u_tick.tick, (k == 3));
                end
            end
            envIf.lrck = 1'b0;
            repeat (3) @(negedge clk);
        end

        // Full ADSR cycle.
        doReset();
        applyStimulus(1'b1, 16'h1000, 16'h0800, 16'h8000, 16'h0400);
        for (int i = 1; i <= 16; i++) begin
            doTick(1'b0, 1'b0);
            checkOutput($sformatf("attack%0d", i), (i == 16) ? 16'hFFFF : 16'(i * 32'h1000),
                        (i == 16) ? 3'd2 : 3'd1);
        end
        for (int i = 1; i <= 16; i++) begin
            doTick(1'b0, 1'b0);
            checkOutput($sformatf("decay%0d", i), (i == 16) ? 16'h8000 : 16'(32'hFFFF - i * 32'h800),
                        (i == 16) ? 3'd3 : 3'd2);
        end
        doTick(1'b0, 1'b0);
        checkOutput("sustainHold", 16'h8000, 3'd3);
`ifdef ZM_ENV_EXP_RELEASE_EN
        envIf.release_rate = 16'h0004;
`endif
        envIf.gate = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("gateFall", 16'h8000, 3'd4);
`ifdef ZM_ENV_EXP_RELEASE_EN
        doTick(1'b0, 1'b0);
        checkOutput("expRel1", 16'h7800, 3'd4);
        doTick(1'b0, 1'b0);
        checkOutput("expRel2", 16'h7080, 3'd4);
        goSustain(16'h000F);
        envIf.release_rate = 16'h0004;
        envIf.gate = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 15; i++) begin
            doTick(1'b0, 1'b0);
            checkOutput($sformatf("expTail%0d", i), 16'(15 - i), (i == 15) ? 3'd0 : 3'd4);
        end
`else
        for (int i = 1; i <= 32; i++) begin
            doTick(1'b0, 1'b0);
            checkOutput($sformatf("release%0d", i), 16'(32'h8000 - i * 32'h400),
                        (i == 32) ? 3'd0 : 3'd4);
        end
`endif

        // Retrigger from RELEASE continues from the current level.
        goSustain(16'h6000);
        envIf.attack_rate = 16'h1000;
        envIf.gate = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("retrigRelease", 16'h6000, 3'd4);
        envIf.gate = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("retrigAttack", 16'h6000, 3'd1);
        doTick(1'b0, 1'b0);
        checkOutput("retrigTick", 16'h7000, 3'd1);

        // Gate fall in the same clk as a tick uses release arithmetic.
        goSustain(16'h8000);
        envIf.release_rate = 16'h0100;
        doTick(1'b1, 1'b0);
`ifdef ZM_ENV_EXP_RELEASE_EN
        checkOutput("fallWithTick", 16'h0000, 3'd0);
`else
        checkOutput("fallWithTick", 16'h7F00, 3'd4);
`endif

        // Saturating linear/exponential release from a small level.
        goSustain(16'h0005);
        envIf.release_rate = 16'hFFFF;
        doTick(1'b1, 1'b0);
`ifdef ZM_ENV_EXP_RELEASE_EN
        checkOutput("releaseSat", 16'h0004, 3'd4);
`else
        checkOutput("releaseSat", 16'h0000, 3'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/zm_adsr_env.md
Name: zm_adsr_env

Overview:
- Sample-rate ADSR envelope generator feeding the VCA amplitude input (vca_level) in the synth top, replacing the static bus-written level.
- Internally derives a one-cycle sample tick from the DAC word clock (lrck, the I2S_LR output of the PCM5102 driver).
- Advances a 16-bit unsigned envelope once per sample, driven by a gate and four bus-written rate and level values.

Parameters:
- LEVEL_W, 16, width of level, sustain and rate values.
- SYNC_STAGES, 2, flops in the lrck synchronizer (minimum 2).

Ports:
- clk, in, 1, system clock; the single clock of the block.
- reset, in, 1, synchronous, active-high reset.
- lrck, in, 1, I2S word clock; asynchronous to the envelope logic, synchronized internally.
- gate, in, 1, note gate, sampled every clk.
- attack_rate, in, LEVEL_W, increment per sample in ATTACK.
- decay_rate, in, LEVEL_W, decrement per sample in DECAY.
- sustain_level, in, LEVEL_W, SUSTAIN target.
- release_rate, in, LEVEL_W, decrement per sample in RELEASE (see Optional Feature).
- level_out, out, LEVEL_W, envelope value, registered.
- stage_out, out, 3, current state encoding.
- active_out, out, 1, high when state is not IDLE.

Behaviour:
- Reset:
  - level_out=0, state=IDLE, stage_out=0, active_out=0.
  - gate history=0, synchronizer flops=0.
  - Reset asserted mid-envelope gives the same result on the next clk edge; the envelope never resumes.
- Tick:
  - tick is a 1-clk pulse on the rising edge of synchronized lrck.
  - tick is asserted SYNC_STAGES+1 clk after the lrck rise.
- Gate edges are detected every clk against a registered gate copy:
  - Rise, from any state: go to ATTACK. level is not zeroed; the attack continues from the current level.
  - Fall, in ATTACK, DECAY or SUSTAIN: go to RELEASE.
  - Fall in IDLE or RELEASE: ignored.
- Gate edge and tick in the same clk:
  - The state transition applies first.
  - The level update on that clk uses the new state's arithmetic.
- Level updates only on tick. Arithmetic uses LEVEL_W+1 bits with saturation.
  - IDLE: level=0.
  - ATTACK: level+attack_rate. If the sum is >= 0xFFFF, level=0xFFFF and next state=DECAY.
  - DECAY: level-decay_rate. If the result is <= sustain_level (incl. underflow), level=sustain_level and next state=SUSTAIN. If sustain_level >= level on entry, the clamp happens on the first tick.
  - SUSTAIN: level=sustain_level every tick; sustain changes are tracked with 1-sample latency.
  - RELEASE: level-release_rate. If the result is <= 0, level=0 and next state=IDLE.
- Zero rate: the level holds in that stage indefinitely. This is legal and not an error.
- level_out changes exactly 1 clk after the tick that caused the update.
- stage_out/active_out are registered and updated in the same cycle as the state register.
- State encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4. Values 5–7 are unreachable; if reached, the next clk returns the state to IDLE with level=0.

Optional Feature:
- Macro: ZM_ENV_EXP_RELEASE_EN.
- Defined: RELEASE computes level - max(level >> release_rate[3:0], 1).
  - This is an exponential decay with a minimum step of 1, so it reaches 0 in finite time.
  - release_rate[15:4] is ignored.
- Undefined: linear release as in Behaviour.
- All other stages are identical in both builds.

Decomposition:
- Package zm_env_pkg:
  - env_state_t enum (3-bit, codes above).
  - LEVEL_MAX = 16'hFFFF.
  - ENV_STAGE_W = 3.
- Sub-module zm_tick_sync:
  - SYNC_STAGES flop synchronizer plus rising-edge detector.
  - Inputs: clk, reset, async_in. Output: tick.
  - Reused by other sample-rate stages (filter coefficient smoothing).

Test Plan:
- Reset and tick latency: reset high mid-ATTACK at level 0x4000 -> next clk level_out=0, stage_out=0. Then toggle lrck -> tick is observed exactly SYNC_STAGES+1 clk after each rise, one per lrck period.
- Full ADSR: attack=0x1000, decay=0x0800, sustain=0x8000, release=0x0400, gate high.
  - Level reaches 0xFFFF on tick 16 and enters DECAY.
  - Reaches 0x8000 on tick 16 of DECAY and enters SUSTAIN.
  - Gate low -> RELEASE; level hits 0 on tick 32 and active_out falls.
- Retrigger: gate drop at level 0x6000 in RELEASE, then gate rise -> state ATTACK, next tick level=0x6000+attack_rate, no dip to 0.
- Saturation and clamping:
  - attack=0xF000 from 0x2000 -> 0xFFFF, not wrap.
  - decay=0xFFFF with sustain=0x1234 -> exactly 0x1234.
  - release=0xFFFF from 0x0005 -> 0.
- Simultaneous events and zero rate:
  - Gate fall on the same clk as a tick in SUSTAIN at 0x8000, release=0x0100 -> level 0x7F00 on that tick.
  - attack_rate=0 -> level frozen, stage stays ATTACK.
- ZM_ENV_EXP_RELEASE_EN build: level 0x8000, release_rate=4 -> next ticks 0x7800, 0x7080. From level 0x000F with shift 4 -> step 1, reaches 0 after 15 ticks.
